// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
//   master : EX side. Drives the request fields, kill_i and resp_ready_i.
//   slave  : muldiv_iter. Drives req_ready_o, resp_valid_o, data_1_o/data_2_o and busy_o.
// The signal names keep the _i/_o suffixes of the unit's port list, seen from the unit.
interface muldiv_if #(
  parameter int XLEN = 64
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            mul_en_i;
  logic            word_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            rs1_sign_i;
  logic            rs2_sign_i;
  logic            kill_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] data_1_o;
  logic [XLEN-1:0] data_2_o;
  logic            busy_o;

  modport master (
    output req_valid_i, mul_en_i, word_i, rs1_data_i, rs2_data_i,
           rs1_sign_i, rs2_sign_i, kill_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, data_1_o, data_2_o, busy_o
  );

  modport slave (
    input  req_valid_i, mul_en_i, word_i, rs1_data_i, rs2_data_i,
           rs1_sign_i, rs2_sign_i, kill_i, resp_ready_i,
    output req_ready_o, resp_valid_o, data_1_o, data_2_o, busy_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit for the RV64M EX stage.
//
// The unit handles MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU and the W forms.
// It is one bit per cycle and works on operand magnitudes. The sign is fixed up
// on the cycle the unit leaves BUSY.
//
// Ports:
//   clk, rst  clock (rising edge) and synchronous active-high reset
//   bus       muldiv_if.slave
//             request:  req_valid_i/req_ready_o, mul_en_i, word_i,
//                       rs1/rs2_data_i, rs1/rs2_sign_i
//             flush:    kill_i
//             response: resp_valid_o/resp_ready_i,
//                       data_1_o (low / quotient), data_2_o (high / remainder)
//             status:   busy_o
//
// Latency:
//   normal op:  result valid N+1 cycles after accept (N = 32 for W forms, else XLEN)
//   divide by zero, signed overflow:  result valid 1 cycle after accept
//
// Build option MULDIV_EARLY_OUT_EN:
//   A multiply leaves BUSY once all remaining multiplier bits are zero.
//   The results are unchanged.
module muldiv_iter #(
  parameter int XLEN = 64
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [XLEN-1:0] cneg(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic n, input logic [2*XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  logic            accept, special, last_iter;
  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_n, dvd_res;

  // Working registers. The same three registers are reused for both operations.
  //   multiply: opa = multiplicand, shifted left each step
  //             opb = multiplier, shifted right each step
  //             acc = running product
  //   divide:   opa[XLEN-1:0] = divisor
  //             opb = dividend bits shifting out at the top,
  //                   quotient bits shifting in at the bottom
  //             acc[XLEN-1:0] = partial remainder
  logic [2*XLEN-1:0] opa_q, opa_d, acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [CW-1:0]     cnt_q, n_last;
  logic              mul_q, word_q, qneg_q, rneg_q;
  logic [XLEN:0]     trial, diff;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_d1, fix_d2;
  logic [XLEN-1:0]   data_1_q, data_2_q;

  // Operand conditioning and the single-cycle divide cases, evaluated in the request cycle
  always_comb begin
    if (bus.word_i) begin
      a_ext = bus.rs1_sign_i ? sext32(bus.rs1_data_i[31:0]) : XLEN'(bus.rs1_data_i[31:0]);
      b_ext = bus.rs2_sign_i ? sext32(bus.rs2_data_i[31:0]) : XLEN'(bus.rs2_data_i[31:0]);
      min_n = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_ext = bus.rs1_data_i;
      b_ext = bus.rs2_data_i;
      min_n = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = bus.rs1_sign_i & a_ext[XLEN-1];
    b_neg    = bus.rs2_sign_i & b_ext[XLEN-1];
    a_mag    = cneg(a_neg, a_ext);
    b_mag    = cneg(b_neg, b_ext);
    div_zero = (b_ext == '0);
    div_ovf  = bus.rs1_sign_i & bus.rs2_sign_i & (a_ext == min_n) & (b_ext == '1);
    special  = ~bus.mul_en_i & (div_zero | div_ovf);
    dvd_res  = bus.word_i ? sext32(bus.rs1_data_i[31:0]) : bus.rs1_data_i;
  end

  assign accept = (state_q == IDLE) & bus.req_valid_i & bus.req_ready_o;

  // One iteration: a shift-add step (multiply) or a restoring subtract step (divide)
  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    acc_d = acc_q;
    trial = '0;
    diff  = '0;
    if (mul_q) begin
      acc_d = opb_q[0] ? acc_q + opa_q : acc_q;
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
    end else begin
      trial = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
      diff  = trial - {1'b0, opa_q[XLEN-1:0]};
      acc_d = {{XLEN{1'b0}}, diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0]};
      opb_d = {opb_q[XLEN-2:0], ~diff[XLEN]};
    end
  end

  // Sign fix-up. It is applied to the result of the final iteration, so the
  // output registers load signed results on the BUSY->DONE edge.
  always_comb begin
    prod_s = cneg2(qneg_q, acc_d);
    quo_s  = cneg(qneg_q, opb_d);
    rem_s  = cneg(rneg_q, acc_d[XLEN-1:0]);
    if (mul_q) begin
      fix_d1 = word_q ? sext32(prod_s[31:0])  : prod_s[XLEN-1:0];
      fix_d2 = word_q ? sext32(prod_s[63:32]) : prod_s[2*XLEN-1:XLEN];
    end else begin
      fix_d1 = word_q ? sext32(quo_s[31:0]) : quo_s;
      fix_d2 = word_q ? sext32(rem_s[31:0]) : rem_s;
    end
  end

  assign n_last = word_q ? CW'(31) : CW'(XLEN-1);

`ifdef MULDIV_EARLY_OUT_EN
  // opb_q[0] is consumed in this cycle, so only the bits above it still matter
  assign last_iter = (cnt_q == n_last) | (mul_q & (opb_q[XLEN-1:1] == '0));
`else
  assign last_iter = (cnt_q == n_last);
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. kill_i takes priority over the request and the response handshake.
  always_comb begin
    state_d = state_q;
    if (bus.kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.req_valid_i) state_d = special ? DONE : BUSY;
        BUSY:    if (last_iter) state_d = DONE;
        DONE:    if (bus.resp_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    bus.req_ready_o  = (state_q == IDLE) & ~bus.kill_i;
    bus.busy_o       = (state_q != IDLE);
    bus.resp_valid_o = (state_q == DONE);
  end

  // Datapath registers. They are not reset because accept always reloads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      mul_q  <= bus.mul_en_i;
      word_q <= bus.word_i;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      cnt_q  <= '0;
      acc_q  <= '0;
      if (bus.mul_en_i) begin
        opa_q <= {{XLEN{1'b0}}, a_mag};
        opb_q <= b_mag;
      end else begin
        opa_q <= {{XLEN{1'b0}}, b_mag};
        // W-form dividend is moved to the top so its MSB is the first bit shifted out
        opb_q <= bus.word_i ? (a_mag << (XLEN-32)) : a_mag;
      end
    end else if (state_q == BUSY) begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Result registers. They are held through DONE and keep their value after a kill.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_1_q <= '0;
      data_2_q <= '0;
    end else if (accept & special) begin
      data_1_q <= div_zero ? '1 : dvd_res;
      data_2_q <= div_zero ? dvd_res : '0;
    end else if ((state_q == BUSY) & last_iter & ~bus.kill_i) begin
      data_1_q <= fix_d1;
      data_2_q <= fix_d2;
    end
  end

  assign bus.data_1_o = data_1_q;
  assign bus.data_2_o = data_2_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter at XLEN=64.
// The reference model computes results from 128-bit signed arithmetic of the extended operands.
module tb_muldiv_iter;
  localparam int XLEN = 64;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus();
  muldiv_iter #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  logic [63:0] exp_d1 = '0;
  logic [63:0] exp_d2 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference model: result values plus the cycle on which resp_valid_o first rises
  function automatic void model(input bit mul, input bit word, input bit s1, input bit s2,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] d1, output logic [63:0] d2,
                                output int lat);
    logic signed [127:0] x, y, p, q, r, ym, mn;
    int n, k;
    n = word ? 32 : 64;
    if (word) begin
      x  = s1 ? {{96{a[31]}}, a[31:0]} : {96'b0, a[31:0]};
      y  = s2 ? {{96{b[31]}}, b[31:0]} : {96'b0, b[31:0]};
      mn = {{97{1'b1}}, 31'b0};
    end else begin
      x  = s1 ? {{64{a[63]}}, a} : {64'b0, a};
      y  = s2 ? {{64{b[63]}}, b} : {64'b0, b};
      mn = {{65{1'b1}}, 63'b0};
    end
    if (mul) begin
      p  = x * y;
      d1 = word ? sx(p[31:0])  : p[63:0];
      d2 = word ? sx(p[63:32]) : p[127:64];
      lat = n + 1;
      if (EARLY) begin
        ym = (y < 0) ? -y : y;
        k = 1;
        for (int i = 0; i < 128; i++) if (ym[i]) k = i + 1;
        lat = k + 1;
      end
    end else if (y == 0) begin
      d1  = '1;
      d2  = word ? sx(a[31:0]) : a;
      lat = 1;
    end else if (x == mn && y == -1) begin
      d1  = word ? sx(a[31:0]) : a;
      d2  = '0;
      lat = 1;
    end else begin
      q   = x / y;
      r   = x % y;
      d1  = word ? sx(q[31:0]) : q[63:0];
      d2  = word ? sx(r[31:0]) : r[63:0];
      lat = n + 1;
    end
  endfunction

  // Compare process: data while a response is on the bus, resp_valid_o low otherwise
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_en) begin
        if (bus.resp_valid_o) begin
          check("resp_data_1", bus.data_1_o, exp_d1);
          check("resp_data_2", bus.data_2_o, exp_d2);
        end
      end else begin
        check("no_resp_expected", 64'(bus.resp_valid_o), 64'd0);
      end
    end
  end

  task automatic do_op(input bit mul, input bit word, input bit s1, input bit s2,
                       input logic [63:0] a, input logic [63:0] b,
                       input int hold, input bit kill_end, input string tag);
    logic [63:0] m1, m2;
    int lat, cyc;
    model(mul, word, s1, s2, a, b, m1, m2, lat);
    @(negedge clk);
    check({tag, "_req_ready"}, 64'(bus.req_ready_o), 64'd1);
    bus.mul_en_i   = mul;
    bus.word_i     = word;
    bus.rs1_sign_i = s1;
    bus.rs2_sign_i = s2;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.req_valid_i = 1'b1;
    exp_d1 = m1;
    exp_d2 = m2;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.rs1_data_i  = {$urandom, $urandom};
    bus.rs2_data_i  = {$urandom, $urandom};
    bus.mul_en_i    = 1'($urandom);
    bus.word_i      = 1'($urandom);
    bus.rs1_sign_i  = 1'($urandom);
    bus.rs2_sign_i  = 1'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.resp_valid_o && cyc < 200);
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    repeat (hold) @(negedge clk);
    bus.resp_ready_i = 1'b1;
    if (kill_end) bus.kill_i = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready_i = 1'b0;
    bus.kill_i       = 1'b0;
    chk_en           = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, 64'(bus.req_ready_o), 64'd1);
    check({tag, "_busy_after"}, 64'(bus.busy_o), 64'd0);
    if (kill_end) check({tag, "_d1_kept"}, bus.data_1_o, m1);
  endtask

  // Pins the model to a hand-computed vector, then runs that vector on the DUT
  task automatic pin_op(input bit mul, input bit word, input bit s1, input bit s2,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] l1, input logic [63:0] l2, input int llat,
                        input int hold, input string tag);
    logic [63:0] m1, m2;
    int lat;
    model(mul, word, s1, s2, a, b, m1, m2, lat);
    check({tag, "_model_d1"}, m1, l1);
    check({tag, "_model_d2"}, m2, l2);
    check({tag, "_model_lat"}, 64'(lat), 64'(llat));
    do_op(mul, word, s1, s2, a, b, hold, 1'b0, tag);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_8000_0000;
      4:       return 64'($urandom_range(0, 20));
      5:       return 64'h0000_0000_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] last_d1, last_d2;
    bus.req_valid_i  = 1'b0;
    bus.mul_en_i     = 1'b0;
    bus.word_i       = 1'b0;
    bus.rs1_data_i   = '0;
    bus.rs2_data_i   = '0;
    bus.rs1_sign_i   = 1'b0;
    bus.rs2_sign_i   = 1'b0;
    bus.kill_i       = 1'b0;
    bus.resp_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_data_1", bus.data_1_o, 64'd0);
    check("rst_data_2", bus.data_2_o, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    pin_op(1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
           64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFF, EARLY ? 4 : 65, 0, "mul_m3x5");
    pin_op(0, 0, 0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 5, "divu_100_7");
    pin_op(0, 0, 1, 1, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 1, 1, "div_by0");
    pin_op(0, 0, 1, 1, 64'h8000_0000_0000_0000, '1,
           64'h8000_0000_0000_0000, 64'd0, 1, 0, "div_ovf");
    pin_op(0, 1, 1, 1, 64'h0000_0000_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0, "divw");
    pin_op(1, 0, 1, 1, 64'd3, 64'd5, 64'd15, 64'd0, EARLY ? 4 : 65, 0, "mul_3x5");

    // kill on BUSY cycle 10: no response, unit idle next cycle, result registers untouched
    last_d1 = exp_d1;
    last_d2 = exp_d2;
    @(negedge clk);
    bus.mul_en_i = 1'b1;  bus.word_i = 1'b0;
    bus.rs1_sign_i = 1'b0; bus.rs2_sign_i = 1'b0;
    bus.rs1_data_i = 64'd123456789; bus.rs2_data_i = 64'hFFFF_0000_FFFF_0000;
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.kill_i = 1'b1;
    @(negedge clk);
    check("kill_busy_during", 64'(bus.busy_o), 64'd1);
    @(posedge clk);
    #1 bus.kill_i = 1'b0;
    @(negedge clk);
    check("kill_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("kill_busy", 64'(bus.busy_o), 64'd0);
    check("kill_d1_kept", bus.data_1_o, last_d1);
    check("kill_d2_kept", bus.data_2_o, last_d2);
    repeat (70) @(negedge clk);
    pin_op(1, 0, 0, 0, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd2, EARLY ? 4 : 65, 0, "mulhu");

    // kill in the same cycle as a request: the request is not taken
    @(negedge clk);
    bus.mul_en_i = 1'b0; bus.rs1_data_i = 64'd9; bus.rs2_data_i = 64'd0;
    bus.req_valid_i = 1'b1; bus.kill_i = 1'b1;
    #1 check("kill_vs_accept_ready", 64'(bus.req_ready_o), 64'd0);
    @(posedge clk);
    #1 begin bus.req_valid_i = 1'b0; bus.kill_i = 1'b0; end
    @(negedge clk);
    check("kill_vs_accept_busy", 64'(bus.busy_o), 64'd0);
    repeat (3) @(negedge clk);

    // reset in the middle of an operation
    @(negedge clk);
    bus.mul_en_i = 1'b0; bus.rs1_data_i = 64'd1000; bus.rs2_data_i = 64'd3;
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 64'(bus.busy_o), 64'd0);
    check("midrst_ready", 64'(bus.req_ready_o), 64'd1);
    check("midrst_valid", 64'(bus.resp_valid_o), 64'd0);
    check("midrst_d1", bus.data_1_o, 64'd0);
    check("midrst_d2", bus.data_2_o, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (70) @(negedge clk);

    for (int t = 0; t < 120; t++) begin
      logic [63:0] a, b;
      bit mul, word, s1, s2;
      mul  = 1'($urandom);
      word = 1'($urandom);
      s1   = 1'($urandom);
      s2   = 1'($urandom);
      a = pick();
      b = pick();
      if ($urandom_range(0, 11) == 0) begin
        s1 = 1'b1; s2 = 1'b1; mul = 1'b0;
        a = word ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        b = '1;
      end
      do_op(mul, word, s1, s2, a, b, $urandom_range(0, 2),
            $urandom_range(0, 9) == 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
